rbus_pkt_outbuf: RTL and testbench

- Two-priority store-and-forward packet buffer on one rbus channel.
- Sits directly downstream of each output port of the N-to-M rbus channel multiplexer.
- Consumes that port's stb/sof/data stream and drives the port's rdy/rdyE back-pressure.
- Releases only complete packets to the sink, so a slow or stalled sink never fragments packets on the link.

---
 rtl/rbus_pkt_outbuf.sv | 253 +++++++++++++++++++++++++
 tb/tb_rbus_pkt_outbuf.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbus_pkt_outbuf.sv
// rbus_pkt_outbuf: two-priority store-and-forward packet buffer for one rbus
// output port. Complete packets only are released to the sink.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_stb/i_sof     input word valid / header word flag
//   i_data[71:0]    input word; header: [71] priority, [67:64] payload count L
//   i_rdy[1:0]      per-priority room for a maximum-size packet (registered)
//   i_rdyE[1:0]     per-priority FIFO empty and not receiving (registered)
//   o_stb/o_sof     output word valid / header flag (registered)
//   o_data[71:0]    output word (registered)
//   o_rdy[1:0]      sink accepts a packet of priority p (sampled at selection)
//   o_rdyE[1:0]     sink path empty, status only
//   ff_err          sticky protocol/overflow error
module rbus_pkt_outbuf #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned PKT_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stb,
    input  logic        i_sof,
    input  logic [71:0] i_data,
    output logic [1:0]  i_rdy,
    output logic [1:0]  i_rdyE,
    output logic        o_stb,
    output logic        o_sof,
    output logic [71:0] o_data,
    input  logic [1:0]  o_rdy,
    input  logic [1:0]  o_rdyE,
    output logic        ff_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = 72;

    typedef enum logic { W_IDLE, W_RX } wr_state_e;
    typedef enum logic { R_IDLE, R_TX } rd_state_e;

    logic [DW-1:0] mem [2][DEPTH];

    wr_state_e     wr_state_q, wr_state_d;
    rd_state_e     rd_state_q, rd_state_d;
    logic          wp_q, wp_d, rp_q, rp_d;
    logic [3:0]    wrem_q, wrem_d, rrem_q, rrem_d;
    logic [PW-1:0] start_q, start_d, resv_q, resv_d;
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] wr_ptr_d [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] rd_ptr_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          err_q, err_d;
    logic          o_stb_q, o_stb_d, o_sof_q, o_sof_d;
    logic [DW-1:0] o_data_q, o_data_d;
    logic [1:0]    rdy_q, rdy_d, rdye_q, rdye_d;

    logic          we_c, wsel_c, hp_c, sel_c, go_c, rx_c;
    logic [AW-1:0] waddr_c;
    logic [3:0]    hl_c;
    logic [1:0]    commit_c, dec_c;
    logic [DW-1:0] rword_c;
    logic [PW-1:0] used_c;
    logic          unused_c;

    assign unused_c = ^o_rdyE;

    // Next-state logic for the write FSM, read FSM, counters and status flags.
    always_comb begin
        wr_state_d = wr_state_q;
        rd_state_d = rd_state_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        wrem_d     = wrem_q;
        rrem_d     = rrem_q;
        start_d    = start_q;
        resv_d     = resv_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        commit_c   = '0;
        dec_c      = '0;
        we_c       = 1'b0;
        wsel_c     = 1'b0;
        waddr_c    = '0;
        hp_c       = i_data[71];
        hl_c       = i_data[67:64];
        sel_c      = 1'b0;
        go_c       = 1'b0;
        rword_c    = '0;
        o_stb_d    = 1'b0;
        o_sof_d    = 1'b0;
        o_data_d   = '0;
        rdy_d      = '0;
        rdye_d     = '0;
        rx_c       = 1'b0;
        used_c     = '0;

        // Write side: a header restarts reception; a full FIFO aborts the packet.
        if (i_stb) begin
            if (i_sof) begin
                if (wr_state_q == W_RX) begin
                    err_d            = 1'b1;
                    wr_ptr_d[wp_q]   = start_q;
                end
                if (PW'(wr_ptr_d[hp_c] - rd_ptr_q[hp_c]) == PW'(DEPTH)) begin
                    err_d      = 1'b1;
                    wr_state_d = W_IDLE;
                end else begin
                    we_c           = 1'b1;
                    wsel_c         = hp_c;
                    waddr_c        = wr_ptr_d[hp_c][AW-1:0];
                    start_d        = wr_ptr_d[hp_c];
                    resv_d         = wr_ptr_d[hp_c] + PW'(hl_c) + PW'(1);
                    wr_ptr_d[hp_c] = wr_ptr_d[hp_c] + PW'(1);
                    wp_d           = hp_c;
                    wrem_d         = hl_c;
                    if (hl_c == 4'd0) begin
                        commit_c[hp_c] = 1'b1;
                        wr_state_d     = W_IDLE;
                    end else begin
                        wr_state_d     = W_RX;
                    end
                end
            end else if (wr_state_q == W_RX) begin
                if (PW'(wr_ptr_q[wp_q] - rd_ptr_q[wp_q]) == PW'(DEPTH)) begin
                    err_d          = 1'b1;
                    wr_ptr_d[wp_q] = start_q;
                    wr_state_d     = W_IDLE;
                end else begin
                    we_c           = 1'b1;
                    wsel_c         = wp_q;
                    waddr_c        = wr_ptr_q[wp_q][AW-1:0];
                    wr_ptr_d[wp_q] = wr_ptr_q[wp_q] + PW'(1);
                    wrem_d         = wrem_q - 4'd1;
                    if (wrem_q == 4'd1) begin
                        commit_c[wp_q] = 1'b1;
                        wr_state_d     = W_IDLE;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end

        // Read side: the header goes out in the selection cycle, then L words.
        case (rd_state_q)
            R_IDLE: begin
                if ((cnt_q[1] != '0) && o_rdy[1]) begin
                    go_c  = 1'b1;
                    sel_c = 1'b1;
                end else if ((cnt_q[0] != '0) && o_rdy[0]) begin
                    go_c  = 1'b1;
                    sel_c = 1'b0;
                end
                if (go_c) begin
                    rword_c         = mem[sel_c][rd_ptr_q[sel_c][AW-1:0]];
                    o_stb_d         = 1'b1;
                    o_sof_d         = 1'b1;
                    o_data_d        = rword_c;
                    rd_ptr_d[sel_c] = rd_ptr_q[sel_c] + PW'(1);
                    rp_d            = sel_c;
                    rrem_d          = rword_c[67:64];
                    if (rword_c[67:64] == 4'd0) begin
                        dec_c[sel_c] = 1'b1;
                    end else begin
                        rd_state_d   = R_TX;
                    end
                end
            end
            default: begin
                rword_c        = mem[rp_q][rd_ptr_q[rp_q][AW-1:0]];
                o_stb_d        = 1'b1;
                o_data_d       = rword_c;
                rd_ptr_d[rp_q] = rd_ptr_q[rp_q] + PW'(1);
                rrem_d         = rrem_q - 4'd1;
                if (rrem_q == 4'd1) begin
                    dec_c[rp_q] = 1'b1;
                    rd_state_d  = R_IDLE;
                end
            end
        endcase

        // Committed counts and post-update status; a packet in flight holds its
        // whole 1+L reservation.
        for (int p = 0; p < 2; p++) begin
            cnt_d[p]  = cnt_q[p] + CW'(commit_c[p]) - CW'(dec_c[p]);
            rx_c      = (wr_state_d == W_RX) && (wp_d == 1'(p));
            used_c    = (rx_c ? resv_d : wr_ptr_d[p]) - rd_ptr_d[p];
            rdy_d[p]  = (PW'(DEPTH) - used_c) >= PW'(PKT_MAX);
            rdye_d[p] = (wr_ptr_d[p] == rd_ptr_d[p]) && !rx_c;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            wrem_q     <= '0;
            rrem_q     <= '0;
            start_q    <= '0;
            resv_q     <= '0;
            wr_ptr_q   <= '{default: '0};
            rd_ptr_q   <= '{default: '0};
            cnt_q      <= '{default: '0};
            err_q      <= 1'b0;
            o_stb_q    <= 1'b0;
            o_sof_q    <= 1'b0;
            o_data_q   <= '0;
            rdy_q      <= 2'b11;
            rdye_q     <= 2'b11;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            wrem_q     <= wrem_d;
            rrem_q     <= rrem_d;
            start_q    <= start_d;
            resv_q     <= resv_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            o_stb_q    <= o_stb_d;
            o_sof_q    <= o_sof_d;
            o_data_q   <= o_data_d;
            rdy_q      <= rdy_d;
            rdye_q     <= rdye_d;
        end
    end

    // Packet storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem[wsel_c][waddr_c] <= i_data;
        end
    end

    assign i_rdy  = rdy_q;
    assign i_rdyE = rdye_q;
    assign o_stb  = o_stb_q;
    assign o_sof  = o_sof_q;
    assign o_data = o_data_q;
    assign ff_err = err_q;

endmodule

// File: tb/tb_rbus_pkt_outbuf.sv
// Testbench for rbus_pkt_outbuf: randomized packets checked against per-priority
// expected word queues plus directed scenarios for arbitration, fill, errors and reset.
module tb_rbus_pkt_outbuf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_stb = 1'b0;
    logic        i_sof = 1'b0;
    logic [71:0] i_data = '0;
    logic [1:0]  i_rdy;
    logic [1:0]  i_rdyE;
    logic        o_stb;
    logic        o_sof;
    logic [71:0] o_data;
    logic [1:0]  o_rdy = 2'b11;
    logic [1:0]  o_rdyE = 2'b11;
    logic        ff_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int raw_out = 0;

    // Reference model: complete packets leave in per-priority arrival order, intact.
    logic [71:0] exp_q0[$];
    logic [71:0] exp_q1[$];
    int          sof_cyc[$];
    bit          sof_p[$];
    bit          in_pkt = 1'b0;
    int          mon_rem = 0;
    bit          cur_p = 1'b0;

    rbus_pkt_outbuf #(.DEPTH(64), .PKT_MAX(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_stb  (i_stb),
        .i_sof  (i_sof),
        .i_data (i_data),
        .i_rdy  (i_rdy),
        .i_rdyE (i_rdyE),
        .o_stb  (o_stb),
        .o_sof  (o_sof),
        .o_data (o_data),
        .o_rdy  (o_rdy),
        .o_rdyE (o_rdyE),
        .ff_err (ff_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Output monitor: framing, no gaps inside a packet, data vs expected queues.
    always @(negedge clk) begin
        logic [71:0] exp_w;
        bit          has;
        if (rst) begin
            in_pkt  = 1'b0;
            mon_rem = 0;
        end else if (o_stb) begin
            raw_out++;
            n_tests++;
            if (o_sof) begin
                if (in_pkt) begin
                    n_fail++;
                    $display("FAIL mon_sof: header with %0d words still owed", mon_rem);
                end
                cur_p   = o_data[71];
                mon_rem = int'(o_data[67:64]);
                in_pkt  = (mon_rem != 0);
                sof_cyc.push_back(cyc);
                sof_p.push_back(cur_p);
            end else if (!in_pkt) begin
                n_fail++;
                $display("FAIL mon_frame: payload word %h outside a packet", o_data);
            end else begin
                mon_rem--;
                if (mon_rem == 0) in_pkt = 1'b0;
            end
            n_tests++;
            has = cur_p ? (exp_q1.size() != 0) : (exp_q0.size() != 0);
            if (!has) begin
                n_fail++;
                $display("FAIL mon_data: unexpected word %h on prio %0d", o_data, cur_p);
            end else begin
                if (cur_p) exp_w = exp_q1.pop_front();
                else       exp_w = exp_q0.pop_front();
                if (o_data !== exp_w) begin
                    n_fail++;
                    $display("FAIL mon_data: got %h, required %h", o_data, exp_w);
                end
            end
        end else if (in_pkt) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon_gap: o_stb=0 with %0d words owed", mon_rem);
            in_pkt = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] rnd_word();
        return 72'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [71:0] make_hdr(input bit p, input int len);
        logic [71:0] w;
        w        = rnd_word();
        w[71]    = p;
        w[67:64] = 4'(len);
        return w;
    endfunction

    task automatic push_exp(input bit p, input logic [71:0] w);
        if (p) exp_q1.push_back(w);
        else   exp_q0.push_back(w);
    endtask

    task automatic drive_word(input bit sof, input logic [71:0] d);
        i_stb  = 1'b1;
        i_sof  = sof;
        i_data = d;
        @(posedge clk); #1;
        i_stb  = 1'b0;
        i_sof  = 1'b0;
    endtask

    task automatic send_pkt(input bit p, input int len, input bit gaps, output logic [71:0] hdr);
        logic [71:0] words[$];
        int tries;
        for (tries = 0; tries < 3000 && i_rdy[p] !== 1'b1; tries++) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (i_rdy[p] !== 1'b1) begin
            n_fail++;
            $display("FAIL send_wait_rdy: i_rdy[%0d]=%b, required 1", p, i_rdy[p]);
        end
        hdr = make_hdr(p, len);
        words.push_back(hdr);
        for (int k = 0; k < len; k++) words.push_back(rnd_word());
        foreach (words[k]) begin
            if (k > 0 && gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            drive_word(k == 0, words[k]);
        end
        foreach (words[k]) push_exp(p, words[k]);
    endtask

    task automatic wait_drain();
        int t;
        for (t = 0; t < 5000; t++) begin
            if (exp_q0.size() == 0 && exp_q1.size() == 0 && !in_pkt && o_stb !== 1'b1) break;
            @(posedge clk); #1;
        end
        n_tests++;
        if (t >= 5000) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d/%0d words still expected", exp_q0.size(), exp_q1.size());
        end
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        i_stb  = 1'b0;
        i_sof  = 1'b0;
        i_data = '0;
        exp_q0.delete();
        exp_q1.delete();
        sof_cyc.delete();
        sof_p.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_tests++;
        if ({o_stb, o_sof} !== 2'b00 || o_data !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_out: stb/sof=%b data=%h, required 00/0", {o_stb, o_sof}, o_data);
        end
        n_tests++;
        if (i_rdy !== 2'b11 || i_rdyE !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_rdy: i_rdy=%b i_rdyE=%b, required 11/11", i_rdy, i_rdyE);
        end
        n_tests++;
        if (ff_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: ff_err=%b, required 0", ff_err);
        end
        apply_reset();
    endtask

    task automatic test_single();
        logic [71:0] hdr;
        o_rdy = 2'b11;
        send_pkt(1'b0, 3, 1'b0, hdr);
        n_tests++;
        if (o_stb !== 1'b0 || i_rdyE[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_t1: o_stb=%b i_rdyE0=%b, required 0/0", o_stb, i_rdyE[0]);
        end
        @(posedge clk); #1;
        n_tests++;
        if (o_stb !== 1'b1 || o_sof !== 1'b1 || o_data !== hdr) begin
            n_fail++;
            $display("FAIL single_lat: stb=%b sof=%b data=%h, required 1/1/%h", o_stb, o_sof, o_data, hdr);
        end
        wait_drain();
        n_tests++;
        if (i_rdyE !== 2'b11 || i_rdy !== 2'b11) begin
            n_fail++;
            $display("FAIL single_empty: i_rdyE=%b i_rdy=%b, required 11/11", i_rdyE, i_rdy);
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] hdr;
        int snap;
        o_rdy = 2'b00;
        sof_cyc.delete();
        sof_p.delete();
        snap = raw_out;
        send_pkt(1'b0, 2, 1'b0, hdr);
        send_pkt(1'b1, 1, 1'b0, hdr);
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (raw_out != snap) begin
            n_fail++;
            $display("FAIL b2b_hold: %0d words out, required 0", raw_out - snap);
        end
        o_rdy = 2'b11;
        wait_drain();
        n_tests++;
        if (sof_p.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: %0d packets, required 2", sof_p.size());
        end else begin
            n_tests++;
            if (sof_p[0] !== 1'b1 || sof_p[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_order: prios %0d,%0d, required 1,0", sof_p[0], sof_p[1]);
            end
            n_tests++;
            if (sof_cyc[1] - sof_cyc[0] != 2) begin
                n_fail++;
                $display("FAIL b2b_gap: sof spacing %0d, required 2", sof_cyc[1] - sof_cyc[0]);
            end
        end
    endtask

    task automatic test_fill();
        logic [71:0] hdr;
        int snap;
        o_rdy = 2'b10;
        snap  = raw_out;
        for (int k = 0; k < 3; k++) send_pkt(1'b0, 15, 1'b1, hdr);
        n_tests++;
        if (i_rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_48: i_rdy0=%b with 16 free, required 1", i_rdy[0]);
        end
        send_pkt(1'b0, 15, 1'b1, hdr);
        n_tests++;
        if (i_rdy !== 2'b10) begin
            n_fail++;
            $display("FAIL fill_64: i_rdy=%b, required 10", i_rdy);
        end
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (raw_out != snap || ff_err !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_hold: out=%0d ff_err=%b, required 0/0", raw_out - snap, ff_err);
        end
        o_rdy = 2'b11;
        wait_drain();
        n_tests++;
        if (i_rdy !== 2'b11 || i_rdyE !== 2'b11) begin
            n_fail++;
            $display("FAIL fill_drain: i_rdy=%b i_rdyE=%b, required 11/11", i_rdy, i_rdyE);
        end
    endtask

    task automatic test_restart_sof();
        logic [71:0] hdr;
        o_rdy = 2'b11;
        sof_p.delete();
        sof_cyc.delete();
        drive_word(1'b1, make_hdr(1'b0, 5));
        drive_word(1'b0, rnd_word());
        drive_word(1'b0, rnd_word());
        send_pkt(1'b0, 2, 1'b0, hdr);
        n_tests++;
        if (ff_err !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_err: ff_err=%b, required 1", ff_err);
        end
        wait_drain();
        n_tests++;
        if (sof_p.size() != 1) begin
            n_fail++;
            $display("FAIL restart_count: %0d packets, required 1", sof_p.size());
        end
        n_tests++;
        if (ff_err !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_sticky: ff_err=%b, required 1", ff_err);
        end
    endtask

    task automatic test_idle_word();
        logic [71:0] w;
        int snap;
        apply_reset();
        snap = raw_out;
        w    = 72'hABC;
        drive_word(1'b0, w);
        n_tests++;
        if (ff_err !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_err: ff_err=%b, required 1", ff_err);
        end
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (i_rdyE !== 2'b11 || i_rdy !== 2'b11 || raw_out != snap) begin
            n_fail++;
            $display("FAIL idle_drop: i_rdyE=%b i_rdy=%b out=%0d, required 11/11/0", i_rdyE, i_rdy, raw_out - snap);
        end
    endtask

    task automatic test_random();
        logic [71:0] hdr;
        bit done;
        apply_reset();
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    send_pkt(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'b1, hdr);
                    if ($urandom_range(0, 2) == 0) begin
                        repeat ($urandom_range(1, 4)) @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    o_rdy = 2'($urandom_range(0, 3));
                end
            end
        join
        o_rdy = 2'b11;
        wait_drain();
        n_tests++;
        if (ff_err !== 1'b0 || i_rdyE !== 2'b11) begin
            n_fail++;
            $display("FAIL random_end: ff_err=%b i_rdyE=%b, required 0/11", ff_err, i_rdyE);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [71:0] hdr;
        int snap;
        int t;
        apply_reset();
        o_rdy = 2'b11;
        send_pkt(1'b0, 7, 1'b0, hdr);
        for (t = 0; t < 10 && !(o_stb === 1'b1 && o_sof === 1'b1); t++) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (o_sof !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_start: o_sof=%b, required 1", o_sof);
        end
        @(posedge clk); #1;
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (o_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_stb: o_stb=%b, required 0", o_stb);
        end
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk); #1;
        rst  = 1'b0;
        snap = raw_out;
        @(posedge clk); #1;
        n_tests++;
        if (i_rdy !== 2'b11 || i_rdyE !== 2'b11) begin
            n_fail++;
            $display("FAIL rstmid_rdy: i_rdy=%b i_rdyE=%b, required 11/11", i_rdy, i_rdyE);
        end
        repeat (20) @(posedge clk);
        #1;
        n_tests++;
        if (raw_out != snap) begin
            n_fail++;
            $display("FAIL rstmid_residual: %0d words out, required 0", raw_out - snap);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_restart_sof();
        test_idle_word();
        test_random();
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
